// File: rtl/codec_pkg.sv
// Shared codec definitions: CRC-32/MPEG-2 constants, the word-wide CRC step
// used by both the appender and the decoder-side checker, and FSM states.
package codec_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic {
        S_DATA = 1'b0,
        S_CRC  = 1'b1
    } state_t;

    // One full 32-bit word per call, bit 31 first, no reflection.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [31:0] data32);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data32[i])
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            else
                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/codeword_crc_appender.sv
// Passes de-interleaved codeword words through and appends a CRC-32 word
// (tlast=1) after every CODEWORD_SIZE_IN_32 words, tagging each word with its index.
module codeword_crc_appender
    import codec_pkg::*;
#(
    parameter int CODEWORD_SIZE_IN_32 = 65,
    parameter int NUM_CODEWORDS       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [1:0]  m_axis_tuser
);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  word_cnt;
    logic [1:0]  cw_idx;
    logic [31:0] crc;

    logic load_ok;
    logic accept;
    logic crc_load;
    logic last_word;

    assign load_ok       = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == S_DATA) && load_ok;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign crc_load      = (state == S_CRC) && load_ok;
    assign last_word     = (word_cnt == 7'(CODEWORD_SIZE_IN_32 - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_DATA: if (accept && last_word) state_nxt = S_CRC;
            S_CRC:  if (load_ok)             state_nxt = S_DATA;
            default:                         state_nxt = S_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_DATA;
        else     state <= state_nxt;
    end

    // Output register: freezes while the consumer stalls, otherwise reloads
    // with the CRC word, a new data word, or goes empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (load_ok) begin
            if (crc_load) begin
                m_axis_tdata  <= crc;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b1;
                m_axis_tuser  <= cw_idx;
            end else if (accept) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= cw_idx;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            cw_idx   <= '0;
            crc      <= CRC32_INIT;
        end else if (accept) begin
            crc      <= crc32_step(crc, s_axis_tdata);
            word_cnt <= last_word ? 7'd0 : word_cnt + 7'd1;
        end else if (crc_load) begin
            crc    <= CRC32_INIT;
            cw_idx <= (cw_idx == 2'(NUM_CODEWORDS - 1)) ? 2'd0 : cw_idx + 2'd1;
        end
    end

endmodule
